// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator call scheduler.
package elevator_pkg;

  localparam int N_FLOORS = 4;
  localparam int FLOOR_W  = 2;

  // next_stage value meaning "no target"
  localparam logic [2:0] NS_NONE = 3'b000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECIDE = 3'd1,
    MOVE   = 3'd2,
    ARRIVE = 3'd3,
    HOLD   = 3'd4
  } state_t;

  // True when any floor strictly beyond 'floor' in the given direction has a call.
  function automatic logic calls_beyond(input logic [N_FLOORS-1:0] calls,
                                        input logic [FLOOR_W-1:0]  floor,
                                        input logic                up);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (calls[i] && (up ? (i > int'(floor)) : (i < int'(floor)))) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/call_target_picker.sv
// Combinational SCAN decision: are calls ahead/behind, which way to go, nearest stop.
module call_target_picker
  import elevator_pkg::*;
(
  input  logic [N_FLOORS-1:0] car_calls,
  input  logic [N_FLOORS-1:0] up_calls,   // floor-indexed, bit 3 always 0
  input  logic [N_FLOORS-1:0] dn_calls,   // floor-indexed, bit 0 always 0
  input  logic [FLOOR_W-1:0]  cur_floor,
  input  logic                dir,
  output logic                ahead,
  output logic                behind,
  output logic                dir_pick,
  output logic [FLOOR_W-1:0]  target
);

  logic [N_FLOORS-1:0] all_calls;
  logic [N_FLOORS-1:0] qual;
  logic [FLOOR_W-1:0]  far;

  // Keep direction while calls lie ahead, otherwise reverse; stop at nearest qualifying floor.
  always_comb begin
    all_calls = car_calls | up_calls | dn_calls;
    ahead     = calls_beyond(all_calls, cur_floor, dir);
    behind    = calls_beyond(all_calls, cur_floor, ~dir);
    dir_pick  = (ahead || !behind) ? dir : ~dir;

    // Farthest call of any type in the chosen direction always qualifies,
    // so the car turns around at the end of its sweep.
    far = cur_floor;
    if (dir_pick) begin
      for (int i = 0; i < N_FLOORS; i++)
        if (i > int'(cur_floor) && all_calls[i]) far = FLOOR_W'(i);
    end else begin
      for (int i = N_FLOORS - 1; i >= 0; i--)
        if (i < int'(cur_floor) && all_calls[i]) far = FLOOR_W'(i);
    end

    qual = car_calls | (dir_pick ? up_calls : dn_calls);
    if (ahead || behind) qual[far] = 1'b1;

    target = cur_floor;
    if (dir_pick) begin
      for (int i = N_FLOORS - 1; i >= 0; i--)
        if (i > int'(cur_floor) && qual[i]) target = FLOOR_W'(i);
    end else begin
      for (int i = 0; i < N_FLOORS; i++)
        if (i < int'(cur_floor) && qual[i]) target = FLOOR_W'(i);
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Collective SCAN call scheduler for a 4-floor car: latches buttons, drives the
// motion FSM's run/direction/next-floor inputs and acknowledges arrivals.
//
// Arrival handshake: arrive_valid is a level held by the motion FSM until
// arrive_ack pulses for one cycle. It is only accepted in MOVE, and only after
// arrive_valid has been seen low since the previous ack (or since reset), so a
// single assertion can never be acknowledged twice.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int DWELL_CYCLES = 10,
  parameter int CNT_W        = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          car_btn,
  input  logic [2:0]          hall_up,
  input  logic [2:0]          hall_dn,
  input  logic                arrive_valid,
  input  logic [FLOOR_W-1:0]  arrive_floor,
  output logic                arrive_ack,
  output logic                run,
  output logic                dir_up,
  output logic [2:0]          next_stage,
  output logic [3:0]          car_lamp,
  output logic [2:0]          up_lamp,
  output logic [2:0]          dn_lamp,
  output logic [FLOOR_W-1:0]  cur_floor
);

  state_t               state_q, state_d;
  logic [3:0]           car_q, car_d;
  logic [2:0]           up_q, up_d;
  logic [2:0]           dn_q, dn_d;
  logic [FLOOR_W-1:0]   cur_q, arr_q;
  logic                 dir_q, armed_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [3:0]           up4, dn4, all4, cur_oh, arr_oh, block, car_mask;
  logic [2:0]           up_mask, dn_mask;
  logic                 dir_in, ahead, behind, dir_pick, go, any_pending;
  logic                 hold_press, accept, dwell_done, arr_ahead;
  logic [FLOOR_W-1:0]   target;

  // Floor-indexed views of the pending calls and the decision inputs.
  always_comb begin
    up4         = {1'b0, up_q};
    dn4         = {dn_q, 1'b0};
    all4        = car_q | up4 | dn4;
    any_pending = |all4;
    cur_oh      = '0;
    cur_oh[cur_q] = 1'b1;
    arr_oh      = '0;
    arr_oh[arr_q] = 1'b1;
    // Direction is pinned at the end floors before deciding.
    if (cur_q == FLOOR_W'(N_FLOORS - 1)) dir_in = 1'b0;
    else if (cur_q == '0)               dir_in = 1'b1;
    else                                dir_in = dir_q;
    go         = ahead | behind;
    hold_press = (state_q == HOLD) &&
                 |((car_btn | {1'b0, hall_up} | {hall_dn, 1'b0}) & cur_oh);
    accept     = (state_q == MOVE) && arrive_valid && armed_q;
    dwell_done = (cnt_q == CNT_W'(DWELL_CYCLES - 1));
    arr_ahead  = calls_beyond(all4, arr_q, dir_q);
  end

  call_target_picker u_picker (
    .car_calls (car_q),
    .up_calls  (up4),
    .dn_calls  (dn4),
    .cur_floor (cur_q),
    .dir       (dir_in),
    .ahead     (ahead),
    .behind    (behind),
    .dir_pick  (dir_pick),
    .target    (target)
  );

  // Next-state logic of the scheduler FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_pending) state_d = DECIDE;
      DECIDE:  state_d = go ? MOVE : IDLE;
      MOVE:    if (accept) state_d = ARRIVE;
      ARRIVE:  state_d = HOLD;
      HOLD:    if (!hold_press && dwell_done) state_d = any_pending ? DECIDE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pending-call update: presses set, served floors clear, clear wins on conflict.
  always_comb begin
    block    = '0;
    car_mask = '0;
    up_mask  = '0;
    dn_mask  = '0;
    case (state_q)
      HOLD:   block = cur_oh;  // door is open here: presses are served immediately
      ARRIVE: begin
        car_mask = arr_oh;
        if (dir_q) up_mask = arr_oh[2:0];
        else       dn_mask = arr_oh[3:1];
        if (!arr_ahead) begin
          up_mask = arr_oh[2:0];
          dn_mask = arr_oh[3:1];
        end
      end
      DECIDE: if (!go) begin
        // Only calls at the current floor remain: treat them as served.
        car_mask = cur_oh;
        up_mask  = cur_oh[2:0];
        dn_mask  = cur_oh[3:1];
      end
      default: ;
    endcase
    car_d = (car_q | (car_btn & ~block)) & ~car_mask;
    up_d  = (up_q | (hall_up & ~block[2:0])) & ~up_mask;
    dn_d  = (dn_q | (hall_dn & ~block[3:1])) & ~dn_mask;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Pending call registers (these are the lamps).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      car_q <= '0;
      up_q  <= '0;
      dn_q  <= '0;
    end else begin
      car_q <= car_d;
      up_q  <= up_d;
      dn_q  <= dn_d;
    end
  end

  // Position, direction, dwell counter and arrival bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q   <= '0;
      arr_q   <= '0;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      if (accept) arr_q <= arrive_floor;
      if (state_q == ARRIVE) cur_q <= arr_q;
      if (state_q == DECIDE) dir_q <= dir_pick;
      if (state_q == ARRIVE)                  cnt_q <= '0;
      else if (hold_press)                    cnt_q <= '0;
      else if (state_q == HOLD && !dwell_done) cnt_q <= cnt_q + 1'b1;
      if (state_q == ARRIVE)  armed_q <= 1'b0;
      else if (!arrive_valid) armed_q <= 1'b1;
    end
  end

  // Output decode.
  always_comb begin
    run        = (state_q == MOVE) || (state_q == DECIDE && go);
    next_stage = run ? {1'b1, target} : NS_NONE;
    dir_up     = (state_q == DECIDE) ? dir_pick : dir_q;
    arrive_ack = (state_q == ARRIVE);
    car_lamp   = car_q;
    up_lamp    = up_q;
    dn_lamp    = dn_q;
    cur_floor  = cur_q;
  end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler.
module tb_elevator_call_scheduler;
  import elevator_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] car_btn;
  logic [2:0] hall_up, hall_dn;
  logic       arrive_valid;
  logic [1:0] arrive_floor;
  logic       arrive_ack, run, dir_up;
  logic [2:0] next_stage;
  logic [3:0] car_lamp;
  logic [2:0] up_lamp, dn_lamp;
  logic [1:0] cur_floor;

  int tests_run = 0;
  int tests_failed = 0;

  elevator_call_scheduler dut (
    .clk(clk), .reset(reset), .car_btn(car_btn), .hall_up(hall_up), .hall_dn(hall_dn),
    .arrive_valid(arrive_valid), .arrive_floor(arrive_floor), .arrive_ack(arrive_ack),
    .run(run), .dir_up(dir_up), .next_stage(next_stage), .car_lamp(car_lamp),
    .up_lamp(up_lamp), .dn_lamp(dn_lamp), .cur_floor(cur_floor)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle car button press from IDLE; lamp must show on the next cycle.
  task automatic press_car(input int f);
    car_btn = 4'(1 << f);
    tick();
    car_btn = '0;
    chk("car_lamp_set", 8'(car_lamp[f]), 8'(1));
    chk("idle_run_low", 8'(run), 8'(0));
  endtask

  // Next cycle is DECIDE, the one after is MOVE.
  task automatic expect_decide(input logic [2:0] ns, input logic d);
    tick();
    chk("decide_state", 8'(dut.state_q), 8'(DECIDE));
    chk("decide_run", 8'(run), 8'(1));
    chk("decide_ns", 8'(next_stage), 8'(ns));
    chk("decide_dir", 8'(dir_up), 8'(d));
    tick();
    chk("move_state", 8'(dut.state_q), 8'(MOVE));
    chk("move_run", 8'(run), 8'(1));
    chk("move_ns", 8'(next_stage), 8'(ns));
  endtask

  // Report arrival; check ack pulse and position; leaves bench at first HOLD cycle.
  task automatic arrive(input int f);
    arrive_valid = 1'b1;
    arrive_floor = 2'(f);
    tick();
    chk("ack_pulse", 8'(arrive_ack), 8'(1));
    chk("arrive_run", 8'(run), 8'(0));
    chk("arrive_ns", 8'(next_stage), 8'(0));
    arrive_valid = 1'b0;
    tick();
    chk("ack_single", 8'(arrive_ack), 8'(0));
    chk("cur_floor", 8'(cur_floor), 8'(f));
    chk("car_lamp_clr", 8'(car_lamp[f]), 8'(0));
  endtask

  // Remaining dwell with nothing pending, ending in IDLE.
  task automatic hold_to_idle();
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("hold_run", 8'(run), 8'(0));
      chk("hold_ack", 8'(arrive_ack), 8'(0));
    end
    chk("hold_state", 8'(dut.state_q), 8'(HOLD));
    tick();
    chk("idle_after_hold", 8'(dut.state_q), 8'(IDLE));
  endtask

  task automatic trip(input int f, input logic [2:0] ns, input logic d);
    press_car(f);
    expect_decide(ns, d);
    arrive(f);
    hold_to_idle();
  endtask

  initial begin
    reset = 1'b1;
    car_btn = '0; hall_up = '0; hall_dn = '0;
    arrive_valid = 1'b0; arrive_floor = '0;
    tick(); tick();
    reset = 1'b0;

    // 1. Quiet after reset
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rst_state", 8'(dut.state_q), 8'(IDLE));
      chk("rst_run", 8'(run), 8'(0));
      chk("rst_ns", 8'(next_stage), 8'(0));
      chk("rst_dir", 8'(dir_up), 8'(1));
    end
    chk("rst_lamps", {1'b0, car_lamp, up_lamp}, 8'(0));
    chk("rst_floor", 8'(cur_floor), 8'(0));
    // arrive_valid outside MOVE is ignored
    arrive_valid = 1'b1; arrive_floor = 2'd2;
    tick();
    chk("ign_ack0", 8'(arrive_ack), 8'(0));
    tick();
    chk("ign_ack1", 8'(arrive_ack), 8'(0));
    chk("ign_floor", 8'(cur_floor), 8'(0));
    arrive_valid = 1'b0;
    tick();

    // 2. Floor 0 to 3; a press during ARRIVE on the served bit loses to the clear
    press_car(3);
    chk("t2_lamp", 8'(car_lamp), 8'(4'b1000));
    expect_decide(3'b111, 1'b1);
    arrive_valid = 1'b1; arrive_floor = 2'd3;
    tick();
    chk("t2_ack", 8'(arrive_ack), 8'(1));
    arrive_valid = 1'b0;
    car_btn = 4'b1000;
    tick();
    car_btn = '0;
    chk("t2_clear_wins", 8'(car_lamp), 8'(0));
    chk("t2_floor", 8'(cur_floor), 8'(3));
    hold_to_idle();

    // At floor 3 the direction is forced down
    trip(0, 3'b100, 1'b0);
    // Floor 0 to 2 going up
    trip(2, 3'b110, 1'b1);
    // 4. At floor 2 heading up, only call behind: reverse
    chk("t4_dir_before", 8'(dir_up), 8'(1));
    trip(0, 3'b100, 1'b0);

    // 3. Retarget to a nearer hall-up call while moving
    press_car(3);
    expect_decide(3'b111, 1'b1);
    hall_up = 3'b010;
    tick();
    hall_up = '0;
    chk("t3_up_lamp", 8'(up_lamp), 8'(3'b010));
    chk("t3_retarget", 8'(next_stage), 8'(3'b101));
    arrive(1);
    chk("t3_up_clr", 8'(up_lamp), 8'(0));
    chk("t3_car_keep", 8'(car_lamp), 8'(4'b1000));
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("t3_dwell", 8'(run), 8'(0));
    end
    expect_decide(3'b111, 1'b1);
    arrive(3);
    hold_to_idle();

    // 5. Press at current floor during HOLD is served and restarts dwell
    trip(0, 3'b100, 1'b0);
    press_car(1);
    expect_decide(3'b101, 1'b1);
    arrive(1);
    tick(); tick(); tick();
    hall_up = 3'b001;
    car_btn = 4'b0010;
    tick();
    hall_up = '0;
    car_btn = '0;
    chk("t5_car_lamp", 8'(car_lamp), 8'(0));
    chk("t5_up_lamp", 8'(up_lamp), 8'(3'b001));
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("t5_dwell_restart", 8'(run), 8'(0));
    end
    expect_decide(3'b100, 1'b0);
    arrive(0);
    chk("t5_up_served", 8'(up_lamp), 8'(0));
    hold_to_idle();

    // 6. Reset during MOVE with three calls pending
    car_btn = 4'b1000; hall_up = 3'b010; hall_dn = 3'b100;
    tick();
    car_btn = '0; hall_up = '0; hall_dn = '0;
    chk("t6_lamps", {1'b0, car_lamp, dn_lamp}, 8'({4'b1000, 3'b100}));
    expect_decide(3'b101, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_car", 8'(car_lamp), 8'(0));
    chk("t6_up", 8'(up_lamp), 8'(0));
    chk("t6_dn", 8'(dn_lamp), 8'(0));
    chk("t6_run", 8'(run), 8'(0));
    chk("t6_ns", 8'(next_stage), 8'(0));
    chk("t6_dir", 8'(dir_up), 8'(1));
    tick();
    reset = 1'b0;
    arrive_valid = 1'b1; arrive_floor = 2'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_ack", 8'(arrive_ack), 8'(0));
      chk("t6_state", 8'(dut.state_q), 8'(IDLE));
    end
    arrive_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
